usb_rx_bit_decoder: RTL
=======================

// Module: usb_rx_bit_decoder
// PURPOSE
//  USB 1.1 receive front end. It sits between the D+/D- input synchronizers and the receive shift register.
//  - Recovers bit timing from an oversampled line.
//  - NRZI-decodes the line and detects bit stuffing and SE0 (EOP).
//  - Drives d_orig, shift_enable and stuff_bit to the shift register.
//  - Flags byte, EOP and stuff-error events to the receive control unit.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per USB bit (96 MHz clk / 12 Mb/s)
//  SAMPLE_POINT  3  phase count at which the line is sampled (0..CLKS_PER_BIT-1)
//  STUFF_LEN     6  consecutive decoded 1s after which a stuff bit is expected
// PORTS
//  clk             in   1  system clock
//  rst             in   1  reset; one clock; reset is asynchronous and active-high
//  d_plus_sync     in   1  synchronized D+
//  d_minus_sync    in   1  synchronized D-
//  rcv_active      in   1  high while the control unit is receiving a packet; low = idle/clear
//  d_orig          out  1  NRZI-decoded bit, valid from the shift_enable pulse until the next one
//  shift_enable    out  1  1-cycle pulse per received bit-time (non-SE0)
//  stuff_bit       out  1  high with shift_enable when the bit is a stuff bit
//  byte_received   out  1  1-cycle pulse after the 8th non-stuff shift of a byte
//  eop             out  1  level, high while SE0 is sampled
//  stuff_error     out  1  1-cycle pulse: expected stuff bit decoded as 1
// BEHAVIOUR
//  Reset values
//  - All outputs are 0 on reset.
//  - Internal state on reset: prev_sample=1 (J), phase=0, ones=0, bitcnt=0, state=IDLE.
//  - All outputs are registered.
//  State machine: IDLE, RUN, STUFF
//  - IDLE: counters are held at reset values.
//  - IDLE->RUN: the first d_plus_sync edge while rcv_active=1.
//  - Any state->IDLE: rcv_active=0, taking effect the next cycle; outputs are 0 that cycle.
//  - Mid-byte abort discards the partial bitcnt.
//  Phase counter
//  - Counts 0..CLKS_PER_BIT-1 and wraps.
//  - A d_plus_sync edge (vs. the previous clk value) reloads the counter so the edge cycle is phase 0.
//  Sampling at phase==SAMPLE_POINT; shift_enable, d_orig and stuff_bit appear on the next clk edge:
//  - SE0 (D+=0, D-=0):
//    - eop=1; no shift_enable.
//    - ones and bitcnt are cleared; state goes to RUN.
//    - eop drops at the first non-SE0 sample.
//  - Otherwise, d_orig = ~(d_plus_sync ^ prev_sample), then prev_sample is updated.
//  - RUN:
//    - shift_enable=1, stuff_bit=0.
//    - A 1 increments ones and a 0 clears it.
//    - When ones reaches STUFF_LEN, go to STUFF.
//    - bitcnt increments.
//    - When bitcnt wraps 7->0, byte_received pulses on the cycle after that shift_enable.
//  - STUFF:
//    - shift_enable=1 and stuff_bit=1; bitcnt is unchanged.
//    - ones=0; go to RUN.
//    - If the decoded bit is 1, stuff_error pulses with that shift_enable.
//  Boundary cases
//  - An edge coincident with SAMPLE_POINT: the sample is taken first, then the counter reloads.
//  - An edge during SE0 resyncs normally.
//  - rst mid-packet: immediate return to reset values.
//  Width: phase is $clog2(CLKS_PER_BIT) bits, bitcnt is 3 bits, ones is $clog2(STUFF_LEN+1) bits.
// STRUCTURE
//  Package usb_rx_pkg holds:
//  - typedef enum {IDLE, RUN, STUFF} rx_bit_state_t
//  - typedef enum {LS_J, LS_K, LS_SE0} line_state_t
//  - localparams USB_CLKS_PER_BIT=8 and USB_STUFF_LEN=6
//  - localparam J_DPLUS=1'b1
//  Sub-module: the phase counter is one instance of flex_counter, with NUM_CNT_BITS=$clog2(CLKS_PER_BIT) and clear driven by the resync edge.
//  The rest of the logic is in this module.
// TESTING (CLKS_PER_BIT=8, SAMPLE_POINT=3)
//  1. Reset and idle:
//     - rst=1 with line idle J -> all outputs 0.
//     - Release rst with rcv_active=0 and toggle D+ -> no shift_enable.
//  2. SYNC 0x80 (KJKJKJKK):
//     - 8 shift_enable pulses, 8 clk apart, each 4 clk after a bit edge.
//     - d_orig = 0,0,0,0,0,0,0,1.
//     - byte_received pulses 1 clk after the 8th shift_enable.
//  3. Data 0xFF:
//     - Six 1s then a stuffed 0 -> stuff_bit on the 7th shift_enable.
//     - byte_received only after the 9th shift_enable.
//     - stuff_error stays 0.
//  4. Seven consecutive no-transition bits -> stuff_bit=1 and stuff_error=1 on the 7th shift_enable.
//  5. Jitter: a bit edge arrives 2 clk early -> phase reloads; the next shift_enable comes 4 clk after that edge; d_orig stays correct.
//  6. EOP and abort:
//     - SE0 for 2 bit-times then J -> eop high for ~16 clk, no shift_enable during SE0, bitcnt cleared.
//     - rcv_active=0 after 3 bits, then a full byte -> byte_received only after 8 new bits.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB 1.1 receive front end.
// Line-state decoding helper used by the bit decoder.
package usb_rx_pkg;

    localparam int USB_CLKS_PER_BIT = 8;
    localparam int USB_STUFF_LEN = 6;
    localparam logic J_DPLUS = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STUFF
    } rx_bit_state_t;

    typedef enum logic [1:0] {
        LS_J,
        LS_K,
        LS_SE0
    } line_state_t;

    function automatic line_state_t line_state(
        input logic dp,
        input logic dm
    );
        if (!dp && !dm) begin
            return LS_SE0;
        end else if (dp == J_DPLUS) begin
            return LS_J;
        end else begin
            return LS_K;
        end
    endfunction

endpackage

// File: rtl/usb_rx_bit_decoder_flex_counter.sv
// Wrapping counter used as the bit-phase counter.
// clear marks the current cycle as count 0, so the next value is 1.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    localparam logic [NUM_CNT_BITS-1:0] ONE =
        {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] count_next;

    // A disabled counter is parked at zero.
    always_comb begin
        count_next = '0;
        if (!count_enable) begin
            count_next = '0;
        end else if (clear) begin
            count_next = (rollover_val == '0) ? '0 : ONE;
        end else if (count_out == rollover_val) begin
            count_next = '0;
        end else begin
            count_next = count_out + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out <= '0;
        end else begin
            count_out <= count_next;
        end
    end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB 1.1 receive bit decoder: clock recovery, NRZI decode,
// bit-unstuffing and SE0 detection in front of the shift register.
module usb_rx_bit_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
    parameter int SAMPLE_POINT = 3,
    parameter int STUFF_LEN    = USB_STUFF_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    input  logic rcv_active,
    output logic d_orig,
    output logic shift_enable,
    output logic stuff_bit,
    output logic byte_received,
    output logic eop,
    output logic stuff_error
);

    localparam int PW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [PW-1:0] LAST_PH = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] SAMPLE_PH = PW'(SAMPLE_POINT);
    localparam logic [OW-1:0] STUFF_ONES = OW'(STUFF_LEN);
    localparam logic [OW-1:0] ONE_OW = OW'(1);

    rx_bit_state_t state;
    logic          prev_sample;
    logic          d_plus_q;
    logic [PW-1:0] phase;
    logic [OW-1:0] ones;
    logic [OW-1:0] ones_inc;
    logic [2:0]    bitcnt;
    logic          byte_pend;
    logic          resync;
    logic          cnt_en;
    logic          sample_now;
    logic          is_se0;
    logic          bit_val;

    assign resync     = d_plus_sync ^ d_plus_q;
    assign cnt_en     = rcv_active && ((state != IDLE) || resync);
    // Sampling uses the pre-reload phase, so a coincident edge
    // still gets its sample before the counter restarts.
    assign sample_now = (state != IDLE) && (phase == SAMPLE_PH);
    assign is_se0     = line_state(d_plus_sync, d_minus_sync) == LS_SE0;
    assign bit_val    = ~(d_plus_sync ^ prev_sample);
    assign ones_inc   = ones + ONE_OW;

    flex_counter #(
        .NUM_CNT_BITS(PW)
    ) u_phase (
        .clk         (clk),
        .rst         (rst),
        .clear       (resync),
        .count_enable(cnt_en),
        .rollover_val(LAST_PH),
        .count_out   (phase)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            prev_sample   <= J_DPLUS;
            d_plus_q      <= J_DPLUS;
            ones          <= '0;
            bitcnt        <= '0;
            byte_pend     <= 1'b0;
            d_orig        <= 1'b0;
            shift_enable  <= 1'b0;
            stuff_bit     <= 1'b0;
            byte_received <= 1'b0;
            eop           <= 1'b0;
            stuff_error   <= 1'b0;
        end else begin
            d_plus_q      <= d_plus_sync;
            shift_enable  <= 1'b0;
            stuff_bit     <= 1'b0;
            stuff_error   <= 1'b0;
            byte_pend     <= 1'b0;
            byte_received <= byte_pend;
            if (!rcv_active) begin
                state         <= IDLE;
                prev_sample   <= J_DPLUS;
                ones          <= '0;
                bitcnt        <= '0;
                d_orig        <= 1'b0;
                eop           <= 1'b0;
                byte_received <= 1'b0;
            end else if (state == IDLE) begin
                if (resync) begin
                    state <= RUN;
                end
            end else if (sample_now) begin
                if (is_se0) begin
                    eop    <= 1'b1;
                    ones   <= '0;
                    bitcnt <= '0;
                    state  <= RUN;
                end else begin
                    eop          <= 1'b0;
                    d_orig       <= bit_val;
                    prev_sample  <= d_plus_sync;
                    shift_enable <= 1'b1;
                    if (state == STUFF) begin
                        stuff_bit   <= 1'b1;
                        stuff_error <= bit_val;
                        ones        <= '0;
                        state       <= RUN;
                    end else begin
                        ones   <= bit_val ? ones_inc : '0;
                        bitcnt <= bitcnt + 3'd1;
                        if (bit_val && ones_inc == STUFF_ONES) begin
                            state <= STUFF;
                        end
                        if (bitcnt == 3'd7) begin
                            byte_pend <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
